// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: sole owner of the shared multi-cycle memory port under the
// I-cache and D-cache. Serialises D write-through and I/D miss fills; a fill is
// eight pipelined word reads of one 16-byte block, with every returned word steered
// to the missing cache together with its word index.
module cache_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORDS  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_miss_req,
  input  logic [ADDR_W-1:0]        i_miss_addr,
  input  logic                     d_miss_req,
  input  logic [ADDR_W-1:0]        d_miss_addr,
  input  logic                     d_wr_req,
  input  logic [ADDR_W-1:0]        d_wr_addr,
  input  logic [DATA_W-1:0]        d_wr_data,
  output logic                     d_wr_ack,
  output logic                     i_fill_vld,
  output logic                     d_fill_vld,
  output logic [$clog2(WORDS)-1:0] fill_word,
  output logic [DATA_W-1:0]        fill_data,
  output logic                     i_fill_done,
  output logic                     d_fill_done,
  output logic                     fetch_stall,
  output logic                     mem_stall,
  output logic                     mem_enable,
  output logic                     mem_wr,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_data_vld
);

  // state   | meaning
  // IDLE    | no access in flight; arbitration happens here
  // WRITE   | single-cycle D write-through on the memory port
  // FILL_I  | issuing/receiving the eight reads of an I-cache block
  // FILL_D  | issuing/receiving the eight reads of a D-cache block

  localparam int IDX_W = $clog2(WORDS);
  localparam int OFF_W = IDX_W + 1;
  localparam int BLK_W = ADDR_W - OFF_W;
  localparam logic [IDX_W:0]   ISS_END  = (IDX_W + 1)'(WORDS);
  localparam logic [IDX_W-1:0] RCV_LAST = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FILL_I, S_FILL_D} state_t;

  state_t           state_q, state_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [IDX_W:0]   iss_q, iss_d;
  logic [IDX_W-1:0] rcv_q, rcv_d;
  logic             last_d_q, last_d_d;   // 1: last completed fill was the D-cache

  // Byte offset within the block is irrelevant: fills always cover the whole block.
  logic unused_offset;
  assign unused_offset = ^{i_miss_addr[OFF_W-1:0], d_miss_addr[OFF_W-1:0]};

  // State register; reset aborts any fill in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      blk_q    <= '0;
      iss_q    <= '0;
      rcv_q    <= '0;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      blk_q    <= blk_d;
      iss_q    <= iss_d;
      rcv_q    <= rcv_d;
      last_d_q <= last_d_d;
    end
  end

  // Next-state: write beats misses, round-robin between two misses, fills run to completion.
  always_comb begin
    state_d  = state_q;
    blk_d    = blk_q;
    iss_d    = iss_q;
    rcv_d    = rcv_q;
    last_d_d = last_d_q;
    case (state_q)
      S_IDLE: begin
        iss_d = '0;
        rcv_d = '0;
        if (d_wr_req) begin
          state_d = S_WRITE;
        end else if (i_miss_req && (!d_miss_req || last_d_q)) begin
          state_d = S_FILL_I;
          blk_d   = i_miss_addr[ADDR_W-1:OFF_W];
        end else if (d_miss_req) begin
          state_d = S_FILL_D;
          blk_d   = d_miss_addr[ADDR_W-1:OFF_W];
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_FILL_I, S_FILL_D: begin
        if (iss_q < ISS_END) iss_d = iss_q + 1'b1;
        if (mem_data_vld) begin
          if (rcv_q == RCV_LAST) begin
            state_d  = S_IDLE;
            iss_d    = '0;
            rcv_d    = '0;
            last_d_d = (state_q == S_FILL_D);
          end else begin
            rcv_d = rcv_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: memory access and fill steering decoded from the current state.
  always_comb begin
    d_wr_ack    = 1'b0;
    i_fill_vld  = 1'b0;
    d_fill_vld  = 1'b0;
    fill_word   = '0;
    fill_data   = '0;
    i_fill_done = 1'b0;
    d_fill_done = 1'b0;
    mem_enable  = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (state_q)
      S_WRITE: begin
        mem_enable = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = d_wr_addr;
        mem_wdata  = d_wr_data;
        d_wr_ack   = 1'b1;
      end
      S_FILL_I, S_FILL_D: begin
        if (iss_q < ISS_END) begin
          mem_enable = 1'b1;
          mem_addr   = {blk_q, iss_q[IDX_W-1:0], 1'b0};
        end
        if (mem_data_vld) begin
          fill_word = rcv_q;
          fill_data = mem_rdata;
          if (state_q == S_FILL_I) begin
            i_fill_vld  = 1'b1;
            i_fill_done = (rcv_q == RCV_LAST);
          end else begin
            d_fill_vld  = 1'b1;
            d_fill_done = (rcv_q == RCV_LAST);
          end
        end
      end
      default: ;
    endcase
  end

  assign fetch_stall = i_miss_req & ~i_fill_done;
  assign mem_stall   = (d_miss_req & ~d_fill_done) | (d_wr_req & ~d_wr_ack);

endmodule
